// File: rtl/sys_array_2x2_drain_if.sv
// sys_array_2x2_drain_if: pop handshake bundle for the two result FIFOs (channels 0 and 1)
interface sys_array_2x2_drain_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] fifo_4_out_data;
  logic fifo_4_read_valid;
  logic fifo_4_read_ready;
  logic [WIDTH-1:0] fifo_5_out_data;
  logic fifo_5_read_valid;
  logic fifo_5_read_ready;
  modport master(
    input fifo_4_out_data, fifo_4_read_ready, fifo_5_out_data, fifo_5_read_ready,
    output fifo_4_read_valid, fifo_5_read_valid
  );
  modport slave(
    output fifo_4_out_data, fifo_4_read_ready, fifo_5_out_data, fifo_5_read_ready,
    input fifo_4_read_valid, fifo_5_read_valid
  );
endinterface

// File: rtl/sys_array_2x2_drain.sv
// sys_array_2x2_drain: drains COUNT words from each of two result FIFOs into a buffer and sums them
module sys_array_2x2_drain #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4,
  parameter int TIMEOUT = 64,
  parameter int ACC_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  sys_array_2x2_drain_if.master fifo,
  input  logic [$clog2(2*COUNT)-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [ACC_WIDTH-1:0] sum0,
  output logic [ACC_WIDTH-1:0] sum1,
  output logic busy,
  output logic valid,
  output logic timeout
);
  localparam int AW = $clog2(2*COUNT);
  localparam int CW = $clog2(COUNT+1);
  localparam int IW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE, ERROR} state_t;
  state_t state;
  logic [CW-1:0] cnt0, cnt1, nxt0, nxt1;
  logic [IW-1:0] idle;
  logic [WIDTH-1:0] buffer [2*COUNT];
  logic pop0, pop1;
  assign fifo.fifo_4_read_valid = state == DRAIN && cnt0 < CW'(COUNT);
  assign fifo.fifo_5_read_valid = state == DRAIN && cnt1 < CW'(COUNT);
  assign pop0 = fifo.fifo_4_read_valid & fifo.fifo_4_read_ready;
  assign pop1 = fifo.fifo_5_read_valid & fifo.fifo_5_read_ready;
  assign nxt0 = cnt0 + CW'(pop0);
  assign nxt1 = cnt1 + CW'(pop1);
  assign busy = state == DRAIN;
  assign valid = state == DONE;
  assign timeout = state == ERROR;
  assign rd_data = int'(rd_addr) < 2*COUNT ? buffer[rd_addr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt0 <= '0;
      cnt1 <= '0;
      idle <= '0;
      sum0 <= '0;
      sum1 <= '0;
      for (int i = 0; i < 2*COUNT; i++) buffer[i] <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            state <= DRAIN;
            cnt0 <= '0;
            cnt1 <= '0;
            idle <= '0;
            sum0 <= '0;
            sum1 <= '0;
          end
        DRAIN: begin
          if (pop0) begin
            buffer[AW'(cnt0)] <= fifo.fifo_4_out_data;
            sum0 <= sum0 + ACC_WIDTH'(fifo.fifo_4_out_data);
          end
          if (pop1) begin
            buffer[AW'(COUNT) + AW'(cnt1)] <= fifo.fifo_5_out_data;
            sum1 <= sum1 + ACC_WIDTH'(fifo.fifo_5_out_data);
          end
          cnt0 <= nxt0;
          cnt1 <= nxt1;
          idle <= (pop0 | pop1) ? '0 : idle + 1'b1;
          // a pop in the limit cycle keeps the run alive
          if (nxt0 == CW'(COUNT) && nxt1 == CW'(COUNT)) state <= DONE;
          else if (!(pop0 | pop1) && idle == IW'(TIMEOUT-1)) state <= ERROR;
        end
        default:
          if (start) state <= IDLE;
      endcase
endmodule

// File: tb/tb_sys_array_2x2_drain.sv
// tb_sys_array_2x2_drain: directed runs with queue-modelled FIFOs and a scoreboard on valid/timeout
module tb_sys_array_2x2_drain;
  logic clk = 0, rst, start;
  logic [2:0] rd_addr;
  logic [15:0] rd_data, sum0, sum1;
  logic busy, valid, timeout;
  int checks = 0, failures = 0;
  sys_array_2x2_drain_if #(.WIDTH(16)) fifo();
  sys_array_2x2_drain #(.ACC_WIDTH(16)) dut(
    .clk(clk), .rst(rst), .start(start), .fifo(fifo), .rd_addr(rd_addr), .rd_data(rd_data),
    .sum0(sum0), .sum1(sum1), .busy(busy), .valid(valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // FIFO models: handshake seen at the edge, queue advanced half a cycle later
  logic [15:0] q0[$], q1[$];
  logic pend0 = 0, pend1 = 0;
  always @(posedge clk) begin
    pend0 <= fifo.fifo_4_read_valid & fifo.fifo_4_read_ready;
    pend1 <= fifo.fifo_5_read_valid & fifo.fifo_5_read_ready;
  end
  always @(negedge clk) begin
    if (pend0 && q0.size() > 0) void'(q0.pop_front());
    if (pend1 && q1.size() > 0) void'(q1.pop_front());
    fifo.fifo_4_read_ready = q0.size() > 0;
    fifo.fifo_4_out_data = q0.size() > 0 ? q0[0] : '0;
    fifo.fifo_5_read_ready = q1.size() > 0;
    fifo.fifo_5_out_data = q1.size() > 0 ? q1[0] : '0;
  end
  typedef struct {bit err; logic [15:0] s0; logic [15:0] s1; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  int busy_cyc = 0;
  logic prev_out = 0;
  always @(negedge clk)
    if (rst) begin
      busy_cyc = 0;
      prev_out = 0;
    end else begin
      if (busy) busy_cyc++;
      if ((valid | timeout) && !prev_out) begin
        if (sb.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_kind", timeout, e.err);
          chk("sb_sum0", sum0, e.s0);
          chk("sb_sum1", sum1, e.s1);
          if (e.lat >= 0) chk("sb_drain_cycles", busy_cyc, e.lat);
        end
        busy_cyc = 0;
      end
      prev_out = valid | timeout;
    end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_out(input int lim);
    int k = 0;
    while (!(valid | timeout) && k < lim) begin
      tick();
      k++;
    end
    if (!(valid | timeout)) chk("wait_out_expired", 0, 1);
    tick();
  endtask
  task automatic load(input logic [15:0] a [4], input logic [15:0] b [4], input int na, input int nb);
    q0.delete();
    q1.delete();
    for (int i = 0; i < na; i++) q0.push_back(a[i]);
    for (int i = 0; i < nb; i++) q1.push_back(b[i]);
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end
  initial begin
    rst = 1;
    start = 0;
    rd_addr = 0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sum0", sum0, 0);
    chk("rst_sum1", sum1, 0);
    chk("rst_rv4", fifo.fifo_4_read_valid, 0);
    chk("rst_rv5", fifo.fifo_5_read_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 0;
    tick();
    // basic dual drain
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, 4, 4);
    sb.push_back('{0, 16'd10, 16'd26, 4});
    pulse_start();
    wait_out(20);
    rd_addr = 5; #1 chk("buf_addr5", rd_data, 6);
    rd_addr = 0; #1 chk("buf_addr0", rd_data, 1);
    rd_addr = 7; #1 chk("buf_addr7", rd_data, 8);
    chk("done_rv4", fifo.fifo_4_read_valid, 0);
    tick(2);
    chk("done_hold", valid, 1);
    pulse_start();
    chk("done_exit_valid", valid, 0);
    chk("done_exit_busy", busy, 0);
    // channel 1 starved, channel 0 finishes first
    load('{10, 20, 30, 40}, '{0, 0, 0, 0}, 4, 0);
    sb.push_back('{0, 16'd100, 16'd12, -1});
    pulse_start();
    tick(8);
    chk("skew_busy", busy, 1);
    chk("skew_rv4", fifo.fifo_4_read_valid, 0);
    chk("skew_rv5", fifo.fifo_5_read_valid, 1);
    chk("skew_sum0", sum0, 100);
    for (int i = 0; i < 4; i++) q1.push_back(16'd3);
    wait_out(30);
    pulse_start();
    // short channel 0 -> timeout 64 cycles after last pop
    load('{1, 2, 3, 0}, '{2, 2, 2, 0}, 3, 3);
    sb.push_back('{1, 16'd6, 16'd6, 67});
    pulse_start();
    wait_out(100);
    chk("to_busy", busy, 0);
    chk("to_flag", timeout, 1);
    rd_addr = 2; #1 chk("to_buf_addr2", rd_data, 3);
    rd_addr = 6; #1 chk("to_buf_addr6", rd_data, 2);
    tick(3);
    chk("to_hold_sum0", sum0, 6);
    chk("to_hold_flag", timeout, 1);
    pulse_start();
    chk("to_exit_flag", timeout, 0);
    chk("to_exit_valid", valid, 0);
    // sum wraps at 16 bits
    load('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{0, 0, 0, 0}, 4, 4);
    sb.push_back('{0, 16'hFFFC, 16'h0, 4});
    pulse_start();
    wait_out(20);
    rd_addr = 3; #1 chk("wrap_buf_addr3", rd_data, 16'hFFFF);
    pulse_start();
    // reset mid-drain
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, 4, 4);
    pulse_start();
    tick(2);
    chk("mid_sum0", sum0, 3);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum0", sum0, 0);
    chk("mid_rst_sum1", sum1, 0);
    chk("mid_rst_rv4", fifo.fifo_4_read_valid, 0);
    chk("mid_rst_rv5", fifo.fifo_5_read_valid, 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      #1 chk("mid_rst_buf", rd_data, 0);
    end
    tick(2);
    rst = 0;
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, 4, 4);
    sb.push_back('{0, 16'd10, 16'd26, 4});
    pulse_start();
    wait_out(20);
    pulse_start();
    // start held through drain must not restart the run
    load('{1, 2, 3, 4}, '{5, 6, 7, 8}, 4, 4);
    sb.push_back('{0, 16'd10, 16'd26, 4});
    start = 1;
    tick(4);
    start = 0;
    wait_out(20);
    tick(2);
    chk("held_done_valid", valid, 1);
    pulse_start();
    chk("held_exit_valid", valid, 0);
    tick(2);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sys_array_2x2_drain.md
SYS_ARRAY_2X2_DRAIN -- requirements
Module: sys_array_2x2_drain

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result word width.
REQ-002 SHALL have parameter COUNT, default 4, results popped per channel per run (1..16).
REQ-003 SHALL have parameter TIMEOUT, default 64, idle-cycle limit while draining (>=2).
REQ-004 SHALL have parameter ACC_WIDTH, default 24, per-channel sum width.
REQ-005 SHALL have one clock and an asynchronous active-high reset; port list starts with clock and reset.
REQ-006 SHALL have clk  input  1  clock; all state changes on rising edge.
REQ-007 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have start  input  1  begin a run; sampled only in IDLE.
REQ-009 SHALL have fifo_4_out_data  input  WIDTH  head word of channel-0 result FIFO.
REQ-010 SHALL have fifo_4_read_valid  output  1  pop request to channel-0 FIFO.
REQ-011 SHALL have fifo_4_read_ready  input  1  channel-0 FIFO non-empty; head word valid.
REQ-012 SHALL have fifo_5_out_data / fifo_5_read_valid / fifo_5_read_ready  same as REQ-009..011 for channel 1.
REQ-013 SHALL have rd_addr  input  $clog2(2*COUNT)  result buffer read index (ch*COUNT + n).
REQ-014 SHALL have rd_data  output  WIDTH  result buffer word at rd_addr, combinational.
REQ-015 SHALL have sum0, sum1  output  ACC_WIDTH  per-channel running sums.
REQ-016 SHALL have busy  output  1  high in DRAIN.
REQ-017 SHALL have valid  output  1  high in DONE.
REQ-018 SHALL have timeout  output  1  high in ERROR.

Function
REQ-019 SHALL implement states IDLE, DRAIN, DONE, ERROR.
REQ-020 IDLE -> DRAIN on start=1; entry clears cnt0, cnt1, sum0, sum1, idle counter; buffer contents retained.
REQ-021 In DRAIN, fifo_N_read_valid SHALL be high iff channel count < COUNT, independent of read_ready (pure request).
REQ-022 A pop on channel N SHALL occur at a rising edge where fifo_N_read_valid=1 and fifo_N_read_ready=1; fifo_N_out_data is captured that same edge.
REQ-023 On pop: buffer[N*COUNT+cnt] <= data; cnt <= cnt+1; sum <= sum + zero-extended data, modulo 2^ACC_WIDTH (wrap, no flag).
REQ-024 Both channels SHALL pop in the same cycle when both qualify; no arbitration, one word per channel per cycle max.
REQ-025 DRAIN -> DONE at the edge where the final required pop makes cnt0=cnt1=COUNT; valid high the next cycle.
REQ-026 Idle counter SHALL clear on any pop, else increment; DRAIN -> ERROR when it reaches TIMEOUT-1 with no pop that cycle.
REQ-027 A pop and timeout in the same cycle: pop wins, counter clears, no ERROR.
REQ-028 DONE and ERROR -> IDLE on start=1 (that start does not also begin a run); otherwise hold.
REQ-029 read_valid SHALL be 0 in IDLE, DONE, ERROR; no pops outside DRAIN.
REQ-030 start asserted during DRAIN SHALL be ignored.
REQ-031 rd_data for rd_addr >= 2*COUNT SHALL be 0.
REQ-032 sum0/sum1/buffer SHALL hold their values in DONE and ERROR.

Reset
REQ-033 rst=1 SHALL immediately force IDLE; read_valid=0, busy=0, valid=0, timeout=0, sum0=sum1=0, counts and idle counter 0.
REQ-034 Buffer contents SHALL be zeroed on reset.
REQ-035 rst asserted mid-DRAIN SHALL abort without any further pop; a pop coinciding with reset assertion is discarded.

Verification
REQ-036 Defaults; both FIFOs preloaded with 1,2,3,4 and 5,6,7,8; pulse start -> 4 consecutive dual pops, valid high 5 cycles after start, sum0=10, sum1=26, rd_addr 5 -> 6.
REQ-037 Channel 1 FIFO empty until 10 cycles after start, then 4 words of 3 -> channel 0 finishes first with fifo_4_read_valid low thereafter; valid after last channel-1 pop, sum1=12.
REQ-038 Channel 0 supplies only 3 words, TIMEOUT=64 -> timeout=1 exactly 64 cycles after last pop, busy=0, sum0 unchanged, then start -> IDLE, timeout=0.
REQ-039 ACC_WIDTH=16, channel 0 words 0xFFFF x4 -> sum0=0xFFFC, no error.
REQ-040 rst pulsed after 2 pops per channel -> all outputs at reset values same cycle, read_valid=0, rd_data=0 at every address; fresh start completes normally.
REQ-041 start held high through DRAIN and DONE -> run not restarted; DONE exits to IDLE on next start edge only.
